// File: rtl/ahb_dec_pkg.sv
// Shared definitions for the AHB bus-matrix decoder: transfer/response
// encodings, the default-slave state type and a transfer-type helper.
package ahb_dec_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

  // NONSEQ and SEQ are the only transfer types that request a data phase.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_dec_default_slave.sv
// Integrated default slave: two-cycle ERROR response FSM plus a saturating
// count of ERROR responses with synchronous clear.
module ahb_dec_default_slave
  import ahb_dec_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       i_sel,
  input  logic       i_ready,
  input  logic [1:0] i_trans,
  input  logic       i_err_clr,
  output logic       o_readyout,
  output logic [1:0] o_resp,
  output logic [7:0] o_err_count
);

  ds_state_e  r_state;
  logic       r_readyout;
  logic [1:0] r_resp;
  logic [7:0] r_err_count;
  logic       w_go;
  logic       w_enter_err1;

  assign w_go         = i_sel & i_ready & is_active_trans(i_trans);
  assign w_enter_err1 = w_go & (r_state != DS_ERR1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= DS_OKAY;
      r_readyout  <= 1'b1;
      r_resp      <= HRESP_OKAY;
      r_err_count <= '0;
    end else begin
      case (r_state)
        DS_ERR1: begin
          r_state    <= DS_ERR2;
          r_readyout <= 1'b1;
          r_resp     <= HRESP_ERROR;
        end
        default: begin
          // OKAY and ERR2 both accept a new request; ERR2 may re-enter ERR1.
          if (w_go) begin
            r_state    <= DS_ERR1;
            r_readyout <= 1'b0;
            r_resp     <= HRESP_ERROR;
          end else begin
            r_state    <= DS_OKAY;
            r_readyout <= 1'b1;
            r_resp     <= HRESP_OKAY;
          end
        end
      endcase

      if (i_err_clr) begin
        r_err_count <= w_enter_err1 ? 8'd1 : '0;
      end else if (w_enter_err1 && (r_err_count != ERR_COUNT_MAX)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign o_readyout  = r_readyout;
  assign o_resp      = r_resp;
  assign o_err_count = r_err_count;

endmodule

// File: rtl/ahb_bus_matrix_decoder_param.sv
// Parametrised bus-matrix decoder with mask/base region table and default slave.
// Optional data-phase wait-timeout monitor enabled by AHB_DEC_TIMEOUT_EN.
module ahb_bus_matrix_decoder_param
  import ahb_dec_pkg::*;
#(
  parameter int unsigned             NUM_PORTS      = 3,
  parameter int unsigned             DEC_LSB        = 10,
  parameter int unsigned             DW             = 32,
  parameter int unsigned             UW             = 32,
  parameter logic [NUM_PORTS*32-1:0] REGION_BASE    = {32'h1000_0000, 32'h0000_0000, 32'h0001_0000},
  parameter logic [NUM_PORTS*32-1:0] REGION_MASK    = {32'hFFFF_8000, 32'hFFFF_8000, 32'hFFFF_E000},
  parameter int unsigned             TIMEOUT_CYCLES = 256
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HREADYS,
  input  logic                   sel_dec,
  input  logic [31-DEC_LSB:0]    decode_addr_dec,
  input  logic [1:0]             trans_dec,
  input  logic [NUM_PORTS-1:0]   active_dec_in,
  input  logic [NUM_PORTS-1:0]   readyout_dec_in,
  input  logic [2*NUM_PORTS-1:0] resp_dec_in,
  input  logic [NUM_PORTS*DW-1:0] rdata_dec_in,
  input  logic [NUM_PORTS*UW-1:0] ruser_dec_in,
  input  logic                   err_clr,
  output logic [NUM_PORTS-1:0]   sel_dec_out,
  output logic                   active_dec,
  output logic                   HREADYOUTS,
  output logic [1:0]             HRESPS,
  output logic [DW-1:0]          HRDATAS,
  output logic [UW-1:0]          HRUSERS,
  output logic [7:0]             err_count,
  output logic                   timeout_evt
);

  localparam int unsigned    PW       = $clog2(NUM_PORTS + 1);
  localparam int unsigned    AW       = 32 - DEC_LSB;
  localparam logic [PW-1:0]  DFT_PORT = PW'(NUM_PORTS);

  if ((NUM_PORTS < 1) || (NUM_PORTS > 8) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
    $error("ahb_bus_matrix_decoder_param: NUM_PORTS must be 1..8 and TIMEOUT_CYCLES >= 1");
  end

  logic [NUM_PORTS-1:0] w_match;
  logic [PW-1:0]        w_dec_port;
  logic [PW-1:0]        w_addr_port;
  logic [PW-1:0]        r_data_port;
  logic                 w_sel_dft;
  logic                 w_active;
  logic                 w_readyout;
  logic [1:0]           w_resp;
  logic [DW-1:0]        w_rdata;
  logic [UW-1:0]        w_ruser;
  logic                 w_ds_readyout;
  logic [1:0]           w_ds_resp;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_region
    localparam logic [AW-1:0] BASE = REGION_BASE[g*32+DEC_LSB +: AW];
    localparam logic [AW-1:0] MASK = REGION_MASK[g*32+DEC_LSB +: AW];
    assign w_match[g]     = ((decode_addr_dec & MASK) == (BASE & MASK));
    assign sel_dec_out[g] = sel_dec & (w_addr_port == PW'(g));
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    w_dec_port = DFT_PORT;
    for (int unsigned i = NUM_PORTS; i > 0; i--) begin
      if (w_match[i-1]) w_dec_port = PW'(i - 1);
    end
  end

  assign w_addr_port = (trans_dec == HTRANS_IDLE) ? r_data_port : w_dec_port;
  assign w_sel_dft   = sel_dec & (w_addr_port == DFT_PORT);

  always_comb begin
    w_active = 1'b1;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_addr_port == PW'(i)) w_active = active_dec_in[i];
    end
  end
  assign active_dec = w_active;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_data_port <= DFT_PORT;
    end else if (HREADYS) begin
      r_data_port <= w_addr_port;
    end
  end

  always_comb begin
    w_readyout = w_ds_readyout;
    w_resp     = w_ds_resp;
    w_rdata    = '0;
    w_ruser    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (r_data_port == PW'(i)) begin
        w_readyout = readyout_dec_in[i];
        w_resp     = resp_dec_in[2*i +: 2];
        w_rdata    = rdata_dec_in[i*DW +: DW];
        w_ruser    = ruser_dec_in[i*UW +: UW];
      end
    end
  end

  assign HREADYOUTS = w_readyout;
  assign HRESPS     = w_resp;
  assign HRDATAS    = w_rdata;
  assign HRUSERS    = w_ruser;

  ahb_dec_default_slave u_default_slave (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .i_sel       (w_sel_dft),
    .i_ready     (HREADYS),
    .i_trans     (trans_dec),
    .i_err_clr   (err_clr),
    .o_readyout  (w_ds_readyout),
    .o_resp      (w_ds_resp),
    .o_err_count (err_count)
  );

`ifdef AHB_DEC_TIMEOUT_EN
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_CAP  = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] r_wait_cnt;
  logic          w_waiting;

  assign w_waiting = (r_data_port < DFT_PORT) & ~w_readyout;

  // Counting past the last value to a hold point makes the pulse one-shot.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wait_cnt <= '0;
    end else if (w_readyout) begin
      r_wait_cnt <= '0;
    end else if (w_waiting && (r_wait_cnt != TO_CAP)) begin
      r_wait_cnt <= r_wait_cnt + TW'(1);
    end
  end

  assign timeout_evt = w_waiting & (r_wait_cnt == TO_LAST);
`else
  assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_bus_matrix_decoder_param.sv
// Scoreboard bench for ahb_bus_matrix_decoder_param: directed vectors push
// per-cycle expectations; a negedge monitor pops and compares them.
module tb_ahb_bus_matrix_decoder_param;
  import ahb_dec_pkg::*;

  localparam int unsigned NP = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned UW = 32;
`ifdef AHB_DEC_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic            HREADYS;
  logic            sel_dec;
  logic [31:0]     addr;
  logic [21:0]     decode_addr_dec;
  logic [1:0]      trans_dec;
  logic [NP-1:0]   active_dec_in;
  logic [NP-1:0]   readyout_dec_in;
  logic [2*NP-1:0] resp_dec_in;
  logic [NP*DW-1:0] rdata_dec_in;
  logic [NP*UW-1:0] ruser_dec_in;
  logic            err_clr;
  logic [NP-1:0]   sel_dec_out;
  logic            active_dec;
  logic            HREADYOUTS;
  logic [1:0]      HRESPS;
  logic [DW-1:0]   HRDATAS;
  logic [UW-1:0]   HRUSERS;
  logic [7:0]      err_count;
  logic            timeout_evt;

  assign decode_addr_dec = addr[31:10];

  ahb_bus_matrix_decoder_param #(
    .NUM_PORTS      (NP),
    .DEC_LSB        (10),
    .DW             (DW),
    .UW             (UW),
    .REGION_BASE    ({32'h1000_0000, 32'h0000_0000, 32'h0001_0000}),
    .REGION_MASK    ({32'hFFFF_8000, 32'hFFFF_8000, 32'hFFFF_E000}),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .HCLK            (HCLK),
    .HRESETn         (HRESETn),
    .HREADYS         (HREADYS),
    .sel_dec         (sel_dec),
    .decode_addr_dec (decode_addr_dec),
    .trans_dec       (trans_dec),
    .active_dec_in   (active_dec_in),
    .readyout_dec_in (readyout_dec_in),
    .resp_dec_in     (resp_dec_in),
    .rdata_dec_in    (rdata_dec_in),
    .ruser_dec_in    (ruser_dec_in),
    .err_clr         (err_clr),
    .sel_dec_out     (sel_dec_out),
    .active_dec      (active_dec),
    .HREADYOUTS      (HREADYOUTS),
    .HRESPS          (HRESPS),
    .HRDATAS         (HRDATAS),
    .HRUSERS         (HRUSERS),
    .err_count       (err_count),
    .timeout_evt     (timeout_evt)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int unsigned cyc;
    int unsigned sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input int unsigned sig);
    case (sig)
      0:       return {29'b0, sel_dec_out};
      1:       return {31'b0, active_dec};
      2:       return {31'b0, HREADYOUTS};
      3:       return {30'b0, HRESPS};
      4:       return HRDATAS;
      5:       return HRUSERS;
      6:       return {24'b0, err_count};
      default: return {31'b0, timeout_evt};
    endcase
  endfunction

  always @(negedge HCLK) begin
    int          k;
    logic [31:0] got;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].cyc == cyc) begin
        got = observe(sb[k].sig);
        vectors++;
        if (got !== sb[k].exp) begin
          miscompares++;
          $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h",
                   sb[k].name, cyc, got, sb[k].exp);
        end
        sb.delete(k);
      end else begin
        k++;
      end
    end
  end

  task automatic push(input int unsigned sig, input logic [31:0] exp, input string name);
    chk_t c;
    c.cyc  = cyc;
    c.sig  = sig;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic expect_dp(input logic rdy, input logic [1:0] resp, input logic [31:0] rd,
                           input logic [31:0] ru, input logic [7:0] ec, input logic to);
    push(2, {31'b0, rdy},  "HREADYOUTS");
    push(3, {30'b0, resp}, "HRESPS");
    push(4, rd,            "HRDATAS");
    push(5, ru,            "HRUSERS");
    push(6, {24'b0, ec},   "err_count");
    push(7, {31'b0, to},   "timeout_evt");
  endtask

  task automatic step(input logic [31:0] a, input logic [1:0] t, input logic s, input logic r,
                      input logic c, input logic [2:0] es, input logic ea);
    addr      = a;
    trans_dec = t;
    sel_dec   = s;
    HREADYS   = r;
    err_clr   = c;
    push(0, {29'b0, es}, "sel_dec_out");
    push(1, {31'b0, ea}, "active_dec");
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [7:0] sat(input int n);
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn         = 1'b0;
    addr            = '0;
    trans_dec       = HTRANS_IDLE;
    sel_dec         = 1'b0;
    HREADYS         = 1'b1;
    err_clr         = 1'b0;
    active_dec_in   = 3'b101;
    readyout_dec_in = 3'b111;
    resp_dec_in     = {2'b10, 2'b00, 2'b00};
    rdata_dec_in    = {32'h3333_3333, 32'h2222_2222, 32'hA5A5_A5A5};
    ruser_dec_in    = {32'h3C3C_3C3C, 32'h2B2B_2B2B, 32'h1A1A_1A1A};
    @(posedge HCLK);
    #1;

    // Reset values; IDLE keeps the default slave as the address port.
    expect_dp(1'b1, 2'b00, 32'h0, 32'h0, 8'd0, 1'b0);
    step(32'h0001_1FFC, HTRANS_IDLE, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    HRESETn = 1'b1;

    expect_dp(1'b1, 2'b00, 32'h0, 32'h0, 8'd0, 1'b0);
    step(32'h2000_0000, HTRANS_IDLE, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);

    vectors++;
    if (HREADYOUTS !== 1'b1) begin
      miscompares++;
      $display("FAIL HREADYOUTS after idle: got %0b, expected 1", HREADYOUTS);
    end
    vectors++;
    if (HRESPS !== 2'b00) begin
      miscompares++;
      $display("FAIL HRESPS after idle: got %0b, expected 00", HRESPS);
    end
    vectors++;
    if (err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL err_count after idle: got %0d, expected 0", err_count);
    end

    expect_dp(1'b1, 2'b00, 32'h0, 32'h0, 8'd0, 1'b0);
    step(32'h0001_1FFC, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, 3'b001, 1'b1);

    expect_dp(1'b1, 2'b00, 32'hA5A5_A5A5, 32'h1A1A_1A1A, 8'd0, 1'b0);
    step(32'h0000_4000, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0);

    expect_dp(1'b1, 2'b00, 32'h2222_2222, 32'h2B2B_2B2B, 8'd0, 1'b0);
    step(32'h1000_0000, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, 3'b100, 1'b1);

    // IDLE to an unmapped address must not reselect.
    expect_dp(1'b1, 2'b10, 32'h3333_3333, 32'h3C3C_3C3C, 8'd0, 1'b0);
    step(32'h2000_0000, HTRANS_IDLE, 1'b1, 1'b1, 1'b0, 3'b100, 1'b1);

    expect_dp(1'b1, 2'b10, 32'h3333_3333, 32'h3C3C_3C3C, 8'd0, 1'b0);
    step(32'h2000_0000, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);

    vectors++;
    if (HREADYOUTS !== 1'b0) begin
      miscompares++;
      $display("FAIL HREADYOUTS in ERR1: got %0b, expected 0", HREADYOUTS);
    end
    vectors++;
    if (HRESPS !== 2'b01) begin
      miscompares++;
      $display("FAIL HRESPS in ERR1: got %0b, expected 01", HRESPS);
    end
    vectors++;
    if (err_count !== 8'd1) begin
      miscompares++;
      $display("FAIL err_count in ERR1: got %0d, expected 1", err_count);
    end

    // Two-cycle ERROR response.
    expect_dp(1'b0, 2'b01, 32'h0, 32'h0, 8'd1, 1'b0);
    step(32'h2000_0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    expect_dp(1'b1, 2'b01, 32'h0, 32'h0, 8'd1, 1'b0);
    step(32'h2000_0000, HTRANS_IDLE, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    expect_dp(1'b1, 2'b00, 32'h0, 32'h0, 8'd1, 1'b0);
    step(32'h2000_0000, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);

    // Reset asserted during ERR1 returns everything to reset values.
    HRESETn = 1'b0;
    expect_dp(1'b1, 2'b00, 32'h0, 32'h0, 8'd0, 1'b0);
    step(32'h2000_0000, HTRANS_IDLE, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    HRESETn = 1'b1;
    expect_dp(1'b1, 2'b00, 32'h0, 32'h0, 8'd0, 1'b0);
    step(32'h2000_0000, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);

    // 256 back-to-back errors saturate at 255; the last ERR2 adds err_clr.
    for (int n = 1; n <= 256; n++) begin
      expect_dp(1'b0, 2'b01, 32'h0, 32'h0, sat(n), 1'b0);
      step(32'h2000_0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
      expect_dp(1'b1, 2'b01, 32'h0, 32'h0, sat(n), 1'b0);
      step(32'h2000_0000, HTRANS_NONSEQ, 1'b1, 1'b1, (n == 256), 3'b000, 1'b1);
    end
    expect_dp(1'b0, 2'b01, 32'h0, 32'h0, 8'd1, 1'b0);
    step(32'h2000_0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    expect_dp(1'b1, 2'b01, 32'h0, 32'h0, 8'd1, 1'b0);
    step(32'h2000_0000, HTRANS_IDLE, 1'b1, 1'b1, 1'b1, 3'b000, 1'b1);
    expect_dp(1'b1, 2'b00, 32'h0, 32'h0, 8'd0, 1'b0);

    // Port 1 stalls for 10 cycles.
    step(32'h0000_4000, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0);
    readyout_dec_in = 3'b101;
    for (int k = 1; k <= 10; k++) begin
      expect_dp(1'b0, 2'b00, 32'h2222_2222, 32'h2B2B_2B2B, 8'd0, TO_ON && (k == 4));
      step(32'h0000_4000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0);
    end
    readyout_dec_in = 3'b111;
    expect_dp(1'b1, 2'b00, 32'h2222_2222, 32'h2B2B_2B2B, 8'd0, 1'b0);
    step(32'h0000_4000, HTRANS_IDLE, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0);

    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    #1;
    while (sb.size() > 0) begin
      miscompares++;
      $display("FAIL %s: got unchecked at cycle %0d, expected checked", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
